// File: rtl/alu_power_managed.sv
// Parametrised ALU with a power-management controller: clock gating, state retention,
// output isolation and a sequenced wake-up of the switchable ALU domain.
module alu_power_managed #(
   parameter int WIDTH            = 8,
   parameter int IDLE_THRESHOLD   = 5,
   parameter int POWER_GATE_DELAY = 2,
   parameter int WAKE_LATENCY     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       opcode,
   input  logic             sleep_disable,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             result_valid,
   output logic             idle_detect,
   output logic             clk_gated,
   output logic             power_gated,
   output logic             iso_en,
   output logic [2:0]       power_state,
   output logic [15:0]      sleep_count
);

   localparam logic [2:0] ST_RUN     = 3'd0;
   localparam logic [2:0] ST_CG      = 3'd1;
   localparam logic [2:0] ST_SAVE    = 3'd2;
   localparam logic [2:0] ST_OFF     = 3'd3;
   localparam logic [2:0] ST_WAKE    = 3'd4;
   localparam logic [2:0] ST_RESTORE = 3'd5;

   localparam int IDLE_W = $clog2(IDLE_THRESHOLD + 1);
   localparam int GATE_W = $clog2(POWER_GATE_DELAY + 1);
   localparam int WAKE_W = $clog2(WAKE_LATENCY + 1);

   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_THRESHOLD);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_THRESHOLD - 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(POWER_GATE_DELAY - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LATENCY - 1);

   logic [2:0]        state_q, state_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;

   logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
   logic [2:0]        op_code_q, op_code_d;
   logic              op_valid_q, op_valid_d;

   logic [WIDTH-1:0]  alu_res_q, alu_res_d, ret_res_q, ret_res_d;
   logic              alu_carry_q, alu_carry_d, ret_carry_q, ret_carry_d;
   logic [WIDTH:0]    alu_full_s;

   logic [WIDTH-1:0]  result_q, result_d;
   logic              carry_q, carry_d, result_valid_q, result_valid_d;
   logic              in_ready_q, in_ready_d, idle_detect_q, idle_detect_d;
   logic              power_gated_q, power_gated_d, iso_en_q, iso_en_d;
   logic [2:0]        power_state_q, power_state_d;
   logic [15:0]       sleep_count_q, sleep_count_d;
   logic              icg_en_q, icg_en_d, icg_en_lat;

   logic              accept_s, wake_req_s;

   function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0]       op);
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {1'b0, a} - {1'b0, b};
         3'd2:    r = {1'b0, a & b};
         3'd3:    r = {1'b0, a | b};
         3'd4:    r = {1'b0, a ^ b};
         3'd5:    r = {1'b0, ~a};
         3'd6:    r = {1'b0, a[WIDTH-2:0], 1'b0};
         3'd7:    r = {2'b00, a[WIDTH-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign accept_s   = in_valid & (state_q == ST_RUN);
   assign wake_req_s = in_valid | sleep_disable;
   assign alu_full_s = alu_calc(op_a_q, op_b_q, op_code_q);

   // Power sequencing FSM; counters clear whenever their state is left.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      gate_cnt_d = '0;
      wake_cnt_d = '0;
      case (state_q)
         ST_RUN: begin
            if (accept_s) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = (idle_cnt_q < IDLE_MAX) ? idle_cnt_q + IDLE_W'(1) : idle_cnt_q;
               if (!sleep_disable && (idle_cnt_q >= IDLE_LAST)) begin
                  state_d = ST_CG;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_CG: begin
            if (wake_req_s) begin
               state_d = ST_RUN;
            end else if (gate_cnt_q == GATE_LAST) begin
               state_d = ST_SAVE;
            end else begin
               gate_cnt_d = gate_cnt_q + GATE_W'(1);
            end
         end
         ST_SAVE:    state_d = wake_req_s ? ST_WAKE : ST_OFF;
         ST_OFF:     state_d = wake_req_s ? ST_WAKE : ST_OFF;
         ST_WAKE: begin
            if (wake_cnt_q == WAKE_LAST) begin
               state_d = ST_RESTORE;
            end else begin
               wake_cnt_d = wake_cnt_q + WAKE_W'(1);
            end
         end
         ST_RESTORE: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase
   end

   // Operand stage, switchable-domain result, and retention capture/restore.
   always_comb begin
      if (accept_s) begin
         op_a_d    = A;
         op_b_d    = B;
         op_code_d = opcode;
      end else begin
         op_a_d    = op_a_q;
         op_b_d    = op_b_q;
         op_code_d = op_code_q;
      end
      op_valid_d = accept_s;

      if (state_q == ST_RESTORE) begin
         alu_res_d   = ret_res_q;
         alu_carry_d = ret_carry_q;
      end else if (state_q == ST_OFF) begin
         alu_res_d   = '0;
         alu_carry_d = 1'b0;
      end else if (op_valid_q) begin
         alu_res_d   = alu_full_s[WIDTH-1:0];
         alu_carry_d = (op_code_q == 3'd0 || op_code_q == 3'd1) ? alu_full_s[WIDTH] : 1'b0;
      end else begin
         alu_res_d   = alu_res_q;
         alu_carry_d = alu_carry_q;
      end

      if ((state_q == ST_CG) && (state_d == ST_SAVE)) begin
         ret_res_d   = alu_res_q;
         ret_carry_d = alu_carry_q;
      end else begin
         ret_res_d   = ret_res_q;
         ret_carry_d = ret_carry_q;
      end
   end

   // Output decode from the next state so every output comes straight off a flop.
   always_comb begin
      in_ready_d    = (state_d == ST_RUN);
      idle_detect_d = (state_d != ST_RUN);
      power_gated_d = (state_d == ST_OFF);
      iso_en_d      = (state_d == ST_SAVE) || (state_d == ST_OFF) ||
                      (state_d == ST_WAKE) || (state_d == ST_RESTORE);
      power_state_d = state_d;
      icg_en_d      = (state_d == ST_RUN) || (state_d == ST_RESTORE);

      if (iso_en_d) begin
         result_d = ret_res_d;
         carry_d  = ret_carry_d;
      end else begin
         result_d = alu_res_d;
         carry_d  = alu_carry_d;
      end
      result_valid_d = op_valid_q & ~iso_en_d;

      if ((state_d == ST_OFF) && (state_q != ST_OFF) && (sleep_count_q != 16'hFFFF)) begin
         sleep_count_d = sleep_count_q + 16'd1;
      end else begin
         sleep_count_d = sleep_count_q;
      end
   end

   // All state, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         idle_cnt_q     <= '0;
         gate_cnt_q     <= '0;
         wake_cnt_q     <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         op_code_q      <= 3'd0;
         op_valid_q     <= 1'b0;
         alu_res_q      <= '0;
         alu_carry_q    <= 1'b0;
         ret_res_q      <= '0;
         ret_carry_q    <= 1'b0;
         result_q       <= '0;
         carry_q        <= 1'b0;
         result_valid_q <= 1'b0;
         in_ready_q     <= 1'b1;
         idle_detect_q  <= 1'b0;
         power_gated_q  <= 1'b0;
         iso_en_q       <= 1'b0;
         power_state_q  <= ST_RUN;
         sleep_count_q  <= 16'd0;
         icg_en_q       <= 1'b1;
      end else begin
         state_q        <= state_d;
         idle_cnt_q     <= idle_cnt_d;
         gate_cnt_q     <= gate_cnt_d;
         wake_cnt_q     <= wake_cnt_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         op_code_q      <= op_code_d;
         op_valid_q     <= op_valid_d;
         alu_res_q      <= alu_res_d;
         alu_carry_q    <= alu_carry_d;
         ret_res_q      <= ret_res_d;
         ret_carry_q    <= ret_carry_d;
         result_q       <= result_d;
         carry_q        <= carry_d;
         result_valid_q <= result_valid_d;
         in_ready_q     <= in_ready_d;
         idle_detect_q  <= idle_detect_d;
         power_gated_q  <= power_gated_d;
         iso_en_q       <= iso_en_d;
         power_state_q  <= power_state_d;
         sleep_count_q  <= sleep_count_d;
         icg_en_q       <= icg_en_d;
      end
   end

   // Integrated clock gate: enable is captured while clk is low so the gated clock never glitches.
   always_latch begin
      if (!clk) begin
         icg_en_lat = icg_en_q;
      end
   end

   assign clk_gated    = clk & icg_en_lat;
   assign in_ready     = in_ready_q;
   assign result       = result_q;
   assign carry        = carry_q;
   assign result_valid = result_valid_q;
   assign idle_detect  = idle_detect_q;
   assign power_gated  = power_gated_q;
   assign iso_en       = iso_en_q;
   assign power_state  = power_state_q;
   assign sleep_count  = sleep_count_q;

endmodule

// File: tb/tb_alu_power_managed.sv
// Directed self-checking bench for alu_power_managed with default parameters.
module tb_alu_power_managed;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  A = 8'd0;
   logic [7:0]  B = 8'd0;
   logic [2:0]  opcode = 3'd0;
   logic        sleep_disable = 1'b0;
   logic [7:0]  result;
   logic        carry;
   logic        result_valid;
   logic        idle_detect;
   logic        clk_gated;
   logic        power_gated;
   logic        iso_en;
   logic [2:0]  power_state;
   logic [15:0] sleep_count;

   int checks = 0;
   int errors = 0;

   // Expected {carry,result} for opcodes 0..7 with A=0xA5, B=0x3C
   logic [8:0] op_exp [8] = '{9'h0E1, 9'h069, 9'h024, 9'h0BD, 9'h099, 9'h05A, 9'h04A, 9'h052};

   alu_power_managed #(
      .WIDTH(8), .IDLE_THRESHOLD(5), .POWER_GATE_DELAY(2), .WAKE_LATENCY(3)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode), .sleep_disable(sleep_disable),
      .result(result), .carry(carry), .result_valid(result_valid),
      .idle_detect(idle_detect), .clk_gated(clk_gated), .power_gated(power_gated),
      .iso_en(iso_en), .power_state(power_state), .sleep_count(sleep_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      ticks(2);
      checks++; if ({carry, result, result_valid} !== 10'd0) begin errors++; $display("FAIL reset_result: got %h expected %h", {carry, result, result_valid}, 10'd0); end
      checks++; if ({in_ready, idle_detect, power_gated, iso_en} !== 4'b1000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {in_ready, idle_detect, power_gated, iso_en}, 4'b1000); end
      checks++; if ({power_state, sleep_count} !== 19'd0) begin errors++; $display("FAIL reset_state: got %h expected %h", {power_state, sleep_count}, 19'd0); end
      reset = 1'b1;
   endtask

   task automatic test_add_sub;
      A = 8'd200; B = 8'd100; opcode = 3'd0; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_latency: got valid=%b expected 0", result_valid); end
      tick();
      checks++; if ({result_valid, carry, result} !== {1'b1, 1'b1, 8'd44}) begin errors++; $display("FAIL add_result: got %h expected %h", {result_valid, carry, result}, {1'b1, 1'b1, 8'd44}); end
      tick();
      checks++; if ({result_valid, result} !== {1'b0, 8'd44}) begin errors++; $display("FAIL add_pulse: got %h expected %h", {result_valid, result}, {1'b0, 8'd44}); end
      A = 8'd3; B = 8'd5; opcode = 3'd1; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      tick();
      checks++; if ({result_valid, carry, result} !== {1'b1, 1'b1, 8'd254}) begin errors++; $display("FAIL sub_borrow: got %h expected %h", {result_valid, carry, result}, {1'b1, 1'b1, 8'd254}); end
   endtask

   task automatic test_back_to_back;
      A = 8'hA5; B = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         opcode = 3'(i); in_valid = 1'b1;
         tick();
         if (i > 0) begin
            checks++; if ({result_valid, carry, result} !== {1'b1, op_exp[i-1]}) begin errors++; $display("FAIL b2b_op%0d: got %h expected %h", i - 1, {result_valid, carry, result}, {1'b1, op_exp[i-1]}); end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if ({result_valid, carry, result} !== {1'b1, op_exp[7]}) begin errors++; $display("FAIL b2b_op7: got %h expected %h", {result_valid, carry, result}, {1'b1, op_exp[7]}); end
      tick();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got valid=%b expected 0", result_valid); end
   endtask

   task automatic test_idle_sleep;
      A = 8'd3; B = 8'd5; opcode = 3'd1; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      ticks(4);
      checks++; if ({power_state, in_ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL idle_4: got %h expected %h", {power_state, in_ready}, {3'd0, 1'b1}); end
      tick();
      checks++; if ({power_state, in_ready, idle_detect, iso_en, power_gated} !== {3'd1, 4'b0100}) begin errors++; $display("FAIL cg_entry: got %b expected %b", {power_state, in_ready, idle_detect, iso_en, power_gated}, {3'd1, 4'b0100}); end
      tick();
      checks++; if (power_state !== 3'd1) begin errors++; $display("FAIL cg_hold: got %0d expected 1", power_state); end
      tick();
      checks++; if ({power_state, iso_en, power_gated, carry, result} !== {3'd2, 1'b1, 1'b0, 1'b1, 8'd254}) begin errors++; $display("FAIL save: got %h expected %h", {power_state, iso_en, power_gated, carry, result}, {3'd2, 1'b1, 1'b0, 1'b1, 8'd254}); end
      tick();
      checks++; if ({power_state, iso_en, power_gated, sleep_count} !== {3'd3, 1'b1, 1'b1, 16'd1}) begin errors++; $display("FAIL off_entry: got %h expected %h", {power_state, iso_en, power_gated, sleep_count}, {3'd3, 1'b1, 1'b1, 16'd1}); end
      ticks(3);
      checks++; if ({power_state, sleep_count, result_valid, carry, result} !== {3'd3, 16'd1, 1'b0, 1'b1, 8'd254}) begin errors++; $display("FAIL off_hold: got %h expected %h", {power_state, sleep_count, result_valid, carry, result}, {3'd3, 16'd1, 1'b0, 1'b1, 8'd254}); end
   endtask

   task automatic test_wake_off;
      A = 8'hF0; B = 8'h3C; opcode = 3'd4; in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if ({power_state, in_ready, iso_en, power_gated} !== {3'd4, 3'b010}) begin errors++; $display("FAIL wake_c%0d: got %b expected %b", i, {power_state, in_ready, iso_en, power_gated}, {3'd4, 3'b010}); end
      end
      tick();
      checks++; if ({power_state, in_ready, iso_en} !== {3'd5, 2'b01}) begin errors++; $display("FAIL restore: got %b expected %b", {power_state, in_ready, iso_en}, {3'd5, 2'b01}); end
      tick();
      checks++; if ({power_state, in_ready, iso_en, carry, result} !== {3'd0, 2'b10, 1'b1, 8'd254}) begin errors++; $display("FAIL run_restored: got %h expected %h", {power_state, in_ready, iso_en, carry, result}, {3'd0, 2'b10, 1'b1, 8'd254}); end
      tick(); in_valid = 1'b0;
      tick();
      checks++; if ({result_valid, carry, result, sleep_count} !== {1'b1, 1'b0, 8'hCC, 16'd1}) begin errors++; $display("FAIL wake_xor: got %h expected %h", {result_valid, carry, result, sleep_count}, {1'b1, 1'b0, 8'hCC, 16'd1}); end
   endtask

   task automatic test_wake_cg;
      ticks(4);
      checks++; if (power_state !== 3'd1) begin errors++; $display("FAIL cg_reach: got %0d expected 1", power_state); end
      A = 8'd1; B = 8'd2; opcode = 3'd0; in_valid = 1'b1;
      tick();
      checks++; if ({power_state, in_ready, sleep_count} !== {3'd0, 1'b1, 16'd1}) begin errors++; $display("FAIL cg_wake: got %h expected %h", {power_state, in_ready, sleep_count}, {3'd0, 1'b1, 16'd1}); end
      tick(); in_valid = 1'b0;
      tick();
      checks++; if ({result_valid, carry, result} !== {2'b10, 8'd3}) begin errors++; $display("FAIL cg_add: got %h expected %h", {result_valid, carry, result}, {2'b10, 8'd3}); end
   endtask

   task automatic test_wake_save;
      ticks(6);
      checks++; if (power_state !== 3'd2) begin errors++; $display("FAIL save_reach: got %0d expected 2", power_state); end
      A = 8'h0F; B = 8'h30; opcode = 3'd3; in_valid = 1'b1;
      tick();
      checks++; if ({power_state, sleep_count} !== {3'd4, 16'd1}) begin errors++; $display("FAIL save_wake: got %h expected %h", {power_state, sleep_count}, {3'd4, 16'd1}); end
      ticks(2);
      checks++; if (power_state !== 3'd4) begin errors++; $display("FAIL save_wake_hold: got %0d expected 4", power_state); end
      tick();
      checks++; if (power_state !== 3'd5) begin errors++; $display("FAIL save_restore: got %0d expected 5", power_state); end
      tick();
      checks++; if ({power_state, in_ready, carry, result} !== {3'd0, 2'b10, 8'd3}) begin errors++; $display("FAIL save_run: got %h expected %h", {power_state, in_ready, carry, result}, {3'd0, 2'b10, 8'd3}); end
      tick(); in_valid = 1'b0;
      tick();
      checks++; if ({result_valid, carry, result} !== {2'b10, 8'h3F}) begin errors++; $display("FAIL save_or: got %h expected %h", {result_valid, carry, result}, {2'b10, 8'h3F}); end
   endtask

   task automatic test_sleep_disable;
      sleep_disable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if ({power_state, in_ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL sd_run_c%0d: got %h expected %h", i, {power_state, in_ready}, {3'd0, 1'b1}); end
      end
      sleep_disable = 1'b0;
      tick();
      checks++; if (power_state !== 3'd1) begin errors++; $display("FAIL sd_release: got %0d expected 1", power_state); end
      ticks(3);
      checks++; if ({power_state, sleep_count} !== {3'd3, 16'd2}) begin errors++; $display("FAIL sd_off: got %h expected %h", {power_state, sleep_count}, {3'd3, 16'd2}); end
      sleep_disable = 1'b1;
      tick();
      checks++; if (power_state !== 3'd4) begin errors++; $display("FAIL sd_wake: got %0d expected 4", power_state); end
      ticks(3);
      checks++; if (power_state !== 3'd5) begin errors++; $display("FAIL sd_restore: got %0d expected 5", power_state); end
      tick();
      checks++; if ({power_state, carry, result} !== {3'd0, 1'b0, 8'h3F}) begin errors++; $display("FAIL sd_run: got %h expected %h", {power_state, carry, result}, {3'd0, 1'b0, 8'h3F}); end
      sleep_disable = 1'b0;
   endtask

   task automatic test_reset_wake;
      ticks(8);
      checks++; if ({power_state, sleep_count} !== {3'd3, 16'd3}) begin errors++; $display("FAIL rw_off: got %h expected %h", {power_state, sleep_count}, {3'd3, 16'd3}); end
      A = 8'd9; B = 8'd9; opcode = 3'd0; in_valid = 1'b1;
      tick();
      checks++; if (power_state !== 3'd4) begin errors++; $display("FAIL rw_wake: got %0d expected 4", power_state); end
      #1 reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if ({power_state, in_ready, idle_detect, power_gated, iso_en} !== {3'd0, 4'b1000}) begin errors++; $display("FAIL rw_flags: got %b expected %b", {power_state, in_ready, idle_detect, power_gated, iso_en}, {3'd0, 4'b1000}); end
      checks++; if ({sleep_count, result_valid, carry, result} !== 26'd0) begin errors++; $display("FAIL rw_values: got %h expected %h", {sleep_count, result_valid, carry, result}, 26'd0); end
      tick();
      reset = 1'b1;
      ticks(8);
      checks++; if ({power_state, sleep_count, carry, result} !== {3'd3, 16'd1, 9'd0}) begin errors++; $display("FAIL rw_reoff: got %h expected %h", {power_state, sleep_count, carry, result}, {3'd3, 16'd1, 9'd0}); end
      sleep_disable = 1'b1;
      ticks(5);
      checks++; if ({power_state, carry, result} !== {3'd0, 9'd0}) begin errors++; $display("FAIL rw_ret_cleared: got %h expected %h", {power_state, carry, result}, {3'd0, 9'd0}); end
      sleep_disable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_idle_sleep();
      test_wake_off();
      test_wake_cg();
      test_wake_save();
      test_sleep_disable();
      test_reset_wake();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
